line_feed_arbiter: RTL and testbench
====================================

Name: line_feed_arbiter

Overview:
Controller that shares the 4-element line buffer between two element producers (source 0 = activations, source 1 = weights). Grants one source per whole line and forwards its 4 elements as registered valid/data beats. Waits for the buffer's one-cycle line-ready pulse before re-arbitrating. Runs a job of a configured number of lines and reports completion, with per-line source tags for the downstream compute sequencer.

Parameters:
DW, 8, element data width; must match the line buffer data bus
ELEMS, 4, elements per line; fixed by the line buffer, not to be overridden
NL_W, 4, width of the line-count configuration and the lines_left counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle job launch; sampled only in IDLE
cfg_lines  in  NL_W  number of lines in the job; sampled with start
req0_valid  in  1  source 0 has an element
req0_data  in  DW  source 0 element
req0_ready  out  1  source 0 element accepted this cycle when valid&ready
req1_valid  in  1  source 1 has an element
req1_data  in  DW  source 1 element
req1_ready  out  1  source 1 element accepted this cycle when valid&ready
buf_valid  out  1  element strobe to the line buffer, registered
buf_data  out  DW  element to the line buffer, registered
buf_line_ready  in  1  one-cycle pulse from the line buffer: a full line is assembled
line_done  out  1  one-cycle pulse: line accepted by the buffer
line_src  out  1  owner of the current or most recent line; valid while line_done=1
lines_left  out  NL_W  lines remaining in the current job
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at job end
err  out  1  sticky: buf_line_ready seen outside WAIT_LINE; cleared by an accepted start

Behaviour:
- Reset (async, rst=1): state=IDLE, rr pointer=0, elem_cnt=0. All outputs 0: req*_ready, buf_valid, buf_data, line_done, line_src, lines_left, busy, done, err.
- States: IDLE, ARB, XFER, WAIT_LINE, FIN.
- IDLE: on start=1, latch lines_left=cfg_lines and clear err.
  - cfg_lines=0 -> FIN.
  - Otherwise -> ARB.
- ARB: the preferred source is rr.
  - Preferred valid -> grant it.
  - Otherwise other source valid -> grant it.
  - Neither valid -> stay in ARB.
  - On grant: owner<=winner, line_src<=winner, elem_cnt<=0, -> XFER.
  - ARB costs exactly one cycle when a request is present.
- XFER: reqN_ready=1 combinationally only for N=owner; the non-owner's ready is 0.
  - Per-beat: each fire (valid&ready) drives buf_valid=1 and buf_data=req data at the next edge (latency 1). Otherwise buf_valid=0 and buf_data holds.
  - Line end: on the ELEMS-th fire -> WAIT_LINE, and ready drops the following cycle.
  - Back-to-back fires: allowed every cycle; a full line takes 4 cycles minimum.
- No interleaving: the owner is held for the whole line even if its valid drops; the other source waits. Lines are never partial, because the line buffer has no flush.
- WAIT_LINE: no ready asserted. On buf_line_ready:
  - pulse line_done for one cycle;
  - lines_left-=1;
  - rr<=~owner;
  - -> FIN if lines_left was 1, else -> ARB.
  - The ready pulse normally arrives 2 cycles after the last buf_valid; there is no timeout.
- FIN: done=1 for one cycle, busy=1, -> IDLE. line_done and done may not coincide with a new start.
- start outside IDLE is ignored. cfg_lines is not re-sampled mid-job.
- buf_line_ready in any state other than WAIT_LINE: sets err; state, counters and line_done are unaffected.
- lines_left arithmetic is unsigned modulo 2^NL_W. The maximum job is 2^NL_W-1 lines.
- Reset mid-line aborts immediately. The line buffer shares the same reset so both restart empty; the controller makes no attempt to complete the partial line.

Test Plan:
- Reset mid-XFER (after 2 beats), then release -> all outputs 0, rr=0, IDLE. A new job starting with source 0 delivers 4 fresh beats.
- start, cfg_lines=2, both sources always valid, data0=0x10..0x17, data1=0x20..0x27 -> line 1: src0 elements 0x10..0x13 on consecutive buf_valid cycles, line_src=0. Line 2: src1 elements 0x20..0x23, line_src=1. Two line_done pulses, then done; lines_left 2->1->0.
- Only source 1 valid, cfg_lines=1 -> ARB grants source 1 despite rr=0; req0_ready stays 0; single line_done, then done.
- Owner source 0 deasserts valid after beat 2 for 3 cycles while source 1 is valid -> no req1_ready during the gap; beats 3-4 come from source 0 when it resumes.
- start with cfg_lines=0 -> busy high one cycle, done pulse, no buf_valid. A second start during a running job -> ignored, lines_left unchanged.
- Inject buf_line_ready during XFER -> err=1 and sticky; the line still completes on the real pulse. The next accepted start clears err.

Source files
------------

// File: rtl/line_feed_arbiter.sv
// Two-source line feeder: grants one producer per whole line into the
// shared line buffer and sequences a job of cfg_lines lines.
`timescale 1ns/1ps
module line_feed_arbiter #(
   parameter int DW    = 8,
   parameter int ELEMS = 4,
   parameter int NL_W  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [NL_W-1:0] cfg_lines,
   input  logic            req0_valid,
   input  logic [DW-1:0]   req0_data,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [DW-1:0]   req1_data,
   output logic            req1_ready,
   output logic            buf_valid,
   output logic [DW-1:0]   buf_data,
   input  logic            buf_line_ready,
   output logic            line_done,
   output logic            line_src,
   output logic [NL_W-1:0] lines_left,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam int CW = $clog2(ELEMS);

   typedef enum logic [2:0] {
      IDLE, ARB, XFER, WAIT_LINE, FIN
   } state_t;

   state_t        state, state_nx;
   logic          rr, owner;
   logic [CW-1:0] elem_cnt;
   logic          grant, winner;
   logic          fire, last, line_ok, accept;
   logic [DW-1:0] fire_data;

   assign grant   = req0_valid | req1_valid;
   assign winner  = rr ? req1_valid : ~req0_valid;
   assign fire    = (state == XFER) &
                    (owner ? req1_valid : req0_valid);
   assign fire_data = owner ? req1_data : req0_data;
   assign last    = fire & (elem_cnt == CW'(ELEMS - 1));
   assign line_ok = (state == WAIT_LINE) & buf_line_ready;
   assign accept  = (state == IDLE) & start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:
            if (start)
               state_nx = (cfg_lines == '0) ? FIN : ARB;
         ARB:
            if (grant) state_nx = XFER;
         XFER:
            if (last) state_nx = WAIT_LINE;
         WAIT_LINE:
            if (buf_line_ready)
               state_nx = (lines_left == NL_W'(1)) ? FIN : ARB;
         FIN:
            state_nx = IDLE;
         default:
            state_nx = IDLE;
      endcase
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      busy       = (state != IDLE);
      done       = (state == FIN);
      if (state == XFER) begin
         req0_ready = ~owner;
         req1_ready = owner;
      end
   end

   // Datapath and bookkeeping; the owner is held until the whole line lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr         <= 1'b0;
         owner      <= 1'b0;
         elem_cnt   <= '0;
         buf_valid  <= 1'b0;
         buf_data   <= '0;
         line_done  <= 1'b0;
         line_src   <= 1'b0;
         lines_left <= '0;
         err        <= 1'b0;
      end else begin
         buf_valid <= fire;
         if (fire) buf_data <= fire_data;
         line_done <= line_ok;
         if (accept)
            lines_left <= cfg_lines;
         else if (line_ok)
            lines_left <= lines_left - 1'b1;
         if (state == ARB && grant) begin
            owner    <= winner;
            line_src <= winner;
            elem_cnt <= '0;
         end else if (fire) begin
            elem_cnt <= elem_cnt + 1'b1;
         end
         if (line_ok) rr <= ~owner;
         // A stray line-ready pulse on the same edge as a start still flags.
         err <= (err & ~accept) |
                (buf_line_ready & (state != WAIT_LINE));
      end
   end

endmodule

// File: tb/tb_line_feed_arbiter.sv
// Scoreboard bench for line_feed_arbiter: directed jobs, queued
// expectations, negedge monitor and a simple line-buffer model.
`timescale 1ns/1ps
module tb_line_feed_arbiter;

   localparam int DW   = 8;
   localparam int NL_W = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [NL_W-1:0] cfg_lines = '0;
   logic            req0_valid = 1'b0;
   logic [DW-1:0]   req0_data = '0;
   logic            req0_ready;
   logic            req1_valid = 1'b0;
   logic [DW-1:0]   req1_data = '0;
   logic            req1_ready;
   logic            buf_valid;
   logic [DW-1:0]   buf_data;
   logic            buf_line_ready;
   logic            line_done;
   logic            line_src;
   logic [NL_W-1:0] lines_left;
   logic            busy;
   logic            done;
   logic            err;

   logic blr_model = 1'b0;
   logic blr_inj   = 1'b0;
   assign buf_line_ready = blr_model | blr_inj;

   line_feed_arbiter #(.DW(DW), .ELEMS(4), .NL_W(NL_W)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_lines(cfg_lines),
      .req0_valid(req0_valid), .req0_data(req0_data),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data),
      .req1_ready(req1_ready),
      .buf_valid(buf_valid), .buf_data(buf_data),
      .buf_line_ready(buf_line_ready),
      .line_done(line_done), .line_src(line_src),
      .lines_left(lines_left), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            src;
      logic [NL_W-1:0] left;
   } ld_t;

   logic [DW-1:0] s0_q[$];
   logic [DW-1:0] s1_q[$];
   logic [DW-1:0] exp_beat[$];
   ld_t           exp_ld[$];
   int            want_dones = 0;
   int            dones = 0;
   int            beats = 0;
   int            r0_seen = 0;
   int            r1_seen = 0;
   int            s0_cnt = 0;
   int            gap_at = -1;
   int            gap = 0;
   int            bcnt = 0;
   int            pend = 0;
   int            checks = 0;
   int            passed = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic go(input logic [NL_W-1:0] n);
      cfg_lines = n;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_dones(input int lim);
      int t;
      t = 0;
      while (dones < want_dones && t < lim) begin
         step();
         t++;
      end
      chk("job_timeout", 32'(dones >= want_dones), 1);
   endtask

   task automatic push_beats(input logic [DW-1:0] base);
      for (int i = 0; i < 4; i++) exp_beat.push_back(base + DW'(i));
   endtask

   task automatic load(input int s, input logic [DW-1:0] base,
                       input int n);
      for (int i = 0; i < n; i++) begin
         if (s == 0) s0_q.push_back(base + DW'(i));
         else        s1_q.push_back(base + DW'(i));
      end
   endtask

   task automatic push_ld(input logic src, input logic [NL_W-1:0] left);
      ld_t e;
      e.src  = src;
      e.left = left;
      exp_ld.push_back(e);
   endtask

   // Sources consume an element on every accepted handshake.
   always @(posedge clk) begin
      if (!rst) begin
         if (req0_valid && req0_ready && s0_q.size() > 0) begin
            void'(s0_q.pop_front());
            s0_cnt++;
         end
         if (req1_valid && req1_ready && s1_q.size() > 0)
            void'(s1_q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (s0_cnt == gap_at && gap > 0) begin
         req0_valid = 1'b0;
         gap--;
      end else begin
         req0_valid = (s0_q.size() > 0);
         req0_data  = (s0_q.size() > 0) ? s0_q[0] : '0;
      end
      req1_valid = (s1_q.size() > 0);
      req1_data  = (s1_q.size() > 0) ? s1_q[0] : '0;
   end

   // Line buffer model: ready pulse two cycles after the fourth beat.
   always @(negedge clk) begin
      blr_model = 1'b0;
      if (rst) begin
         bcnt = 0;
         pend = 0;
      end else begin
         if (pend > 0) begin
            pend--;
            if (pend == 0) blr_model = 1'b1;
         end
         if (buf_valid) begin
            bcnt++;
            if (bcnt == 4) begin
               bcnt = 0;
               pend = 2;
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents an output.
   always @(negedge clk) begin
      ld_t e;
      if (!rst) begin
         if (buf_valid) begin
            beats++;
            if (exp_beat.size() == 0) begin
               checks++;
               $display("FAIL beat_unexpected: got %0h want none",
                        buf_data);
            end else begin
               chk("beat_data", 32'(buf_data), 32'(exp_beat.pop_front()));
            end
         end
         if (line_done) begin
            if (exp_ld.size() == 0) begin
               checks++;
               $display("FAIL line_done_unexpected: got 1 want 0");
            end else begin
               e = exp_ld.pop_front();
               chk("line_src", 32'(line_src), 32'(e.src));
               chk("ld_lines_left", 32'(lines_left), 32'(e.left));
            end
         end
         if (done) begin
            dones++;
            chk("done_busy", 32'(busy), 1);
            chk("done_expected", 32'(dones <= want_dones), 1);
         end
         if (req0_ready) r0_seen++;
         if (req1_ready) r1_seen++;
      end
   end

   initial begin
      int b0;
      int t;
      repeat (3) step();
      chk("rst_outs",
          {buf_valid, buf_data, line_done, line_src, lines_left,
           busy, done, err, req0_ready, req1_ready}, 0);
      rst = 1'b0;
      step();
      chk("idle_busy", 32'(busy), 0);

      // Abort a line after two beats.
      load(0, 8'hA0, 4);
      exp_beat.push_back(8'hA0);
      exp_beat.push_back(8'hA1);
      go(1);
      t = 0;
      while (beats < 2 && t < 50) begin
         step();
         t++;
      end
      chk("abort_beats", 32'(beats), 2);
      rst = 1'b1;
      s0_q.delete();
      step();
      chk("midrst_outs",
          {buf_valid, buf_data, line_done, line_src, lines_left,
           busy, done, err, req0_ready, req1_ready}, 0);
      rst = 1'b0;
      step();

      // Two lines, both sources streaming: rr starts at source 0.
      load(0, 8'h10, 8);
      load(1, 8'h20, 8);
      push_beats(8'h10);
      push_beats(8'h20);
      push_ld(1'b0, 4'd1);
      push_ld(1'b1, 4'd0);
      want_dones++;
      go(2);
      chk("ll_start", 32'(lines_left), 2);
      chk("busy_run", 32'(busy), 1);
      wait_dones(200);
      step();
      chk("ll_end", 32'(lines_left), 0);
      chk("busy_end", 32'(busy), 0);
      s0_q.delete();
      s1_q.delete();
      step();

      // Only source 1 valid while rr points at source 0.
      load(1, 8'h40, 4);
      push_beats(8'h40);
      push_ld(1'b1, 4'd0);
      want_dones++;
      r0_seen = 0;
      go(1);
      wait_dones(200);
      chk("r0_never", 32'(r0_seen), 0);
      step();

      // Owner stalls after beat 2; source 1 must not slip in.
      load(0, 8'h30, 4);
      load(1, 8'h50, 4);
      s0_cnt = 0;
      gap_at = 2;
      gap = 3;
      push_beats(8'h30);
      push_ld(1'b0, 4'd0);
      want_dones++;
      r1_seen = 0;
      go(1);
      wait_dones(200);
      chk("r1_gap", 32'(r1_seen), 0);
      gap_at = -1;
      s1_q.delete();
      step();
      step();

      // Empty job.
      want_dones++;
      go(0);
      chk("zero_busy", 32'(busy), 1);
      chk("zero_done", 32'(done), 1);
      step();
      chk("zero_idle", 32'(busy), 0);

      // Start while busy is ignored.
      want_dones++;
      go(2);
      step();
      go(5);
      chk("ign_ll", 32'(lines_left), 2);
      chk("ign_busy", 32'(busy), 1);
      load(1, 8'h60, 4);
      load(0, 8'h70, 4);
      push_beats(8'h60);
      push_beats(8'h70);
      push_ld(1'b1, 4'd1);
      push_ld(1'b0, 4'd0);
      wait_dones(200);
      step();

      // Stray line-ready during XFER.
      load(0, 8'h80, 4);
      push_beats(8'h80);
      push_ld(1'b0, 4'd0);
      want_dones++;
      b0 = beats;
      go(1);
      t = 0;
      while (beats < b0 + 1 && t < 50) begin
         step();
         t++;
      end
      blr_inj = 1'b1;
      step();
      blr_inj = 1'b0;
      step();
      chk("err_set", 32'(err), 1);
      wait_dones(200);
      step();
      chk("err_sticky", 32'(err), 1);
      want_dones++;
      go(0);
      chk("err_clear", 32'(err), 0);
      wait_dones(20);
      step();

      chk("beats_left", 32'(exp_beat.size()), 0);
      chk("ld_left", 32'(exp_ld.size()), 0);
      chk("done_count", 32'(dones), 32'(want_dones));
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
